// File: rtl/tt_test_pkg.sv
// Shared types and constants for the multi-channel test core.
package tt_test_pkg;

    // Per-channel update behaviour applied on each prescaler tick.
    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_MISR  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    // Command opcodes carried in ui_in[6:5].
    typedef enum logic [1:0] {
        OP_SET_MODE = 2'd0,
        OP_SET_DIV  = 2'd1,
        OP_SELECT   = 2'd2,
        OP_CLEAR    = 2'd3
    } op_e;

    // ui_in field positions.
    localparam int UI_STB    = 7;
    localparam int UI_OP_LO  = 5;
    localparam int UI_CH_LO  = 3;
    localparam int UI_ARG_LO = 0;

    // Command word as laid out on ui_in[7:0], MSB first.
    typedef struct packed {
        logic       stb;
        op_e        op;
        logic [1:0] ch;
        logic [2:0] arg;
    } cmd_t;

    localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/tt_test_channel.sv
// One pattern/signature channel: state register plus mode-dependent next state.
module tt_test_channel
    import tt_test_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] nxt;

    // Galois shift shared by LFSR and MISR; MISR skips the zero-lockup guard.
    always_comb begin
        lfsr_step = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? TAPS : '0);
        nxt       = state;
        case (mode)
            MODE_COUNT: nxt = state + WIDTH'(1);
            MODE_LFSR:  nxt = (state == '0) ? WIDTH'(1) : lfsr_step;
            MODE_MISR:  nxt = lfsr_step ^ din;
            default:    nxt = state;
        endcase
    end

    // Clear beats tick so a CLEAR landing on a tick cycle leaves zero.
    always_ff @(posedge clk) begin
        if (rst)
            state <= '0;
        else if (clear)
            state <= '0;
        else if (tick)
            state <= nxt;
    end

endmodule

// File: rtl/tt_test_core_mc.sv
// Multi-channel test core: command decoder, prescaler and NUM_CH channels.
module tt_test_core_mc
    import tt_test_pkg::*;
#(
    parameter int             WIDTH     = 8,
    parameter int             NUM_CH    = 4,
    parameter int             DIV_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEF_LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [WIDTH-1:0] uio_out,
    output logic [WIDTH-1:0] uio_oe
);

    cmd_t                         cmd;
    logic                         strobe_q;
    logic                         fire;
    logic [2:0]                   div_sh;
    logic [DIV_W-1:0]             prescaler;
    logic [DIV_W-1:0]             tick_lim;
    logic                         tick;
    logic [1:0]                   out_sel;
    logic [3:0]                   cmd_cnt;
    mode_e [NUM_CH-1:0]           mode_q;
    logic [NUM_CH-1:0][WIDTH-1:0] state;
    logic [WIDTH-1:0]             sel_state;
    mode_e                        sel_mode;

    assign cmd      = cmd_t'(ui_in[7:0]);
    assign fire     = ena && cmd.stb && !strobe_q;
    assign tick_lim = (DIV_W'(1) << div_sh) - DIV_W'(1);
    assign tick     = ena && (prescaler == tick_lim);

    // Strobe edge detect, prescaler and command-driven configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q  <= 1'b0;
            div_sh    <= '0;
            prescaler <= '0;
            out_sel   <= '0;
            cmd_cnt   <= '0;
            for (int i = 0; i < NUM_CH; i++) mode_q[i] <= MODE_COUNT;
        end else begin
            strobe_q <= cmd.stb;
            if (ena)
                prescaler <= tick ? '0 : prescaler + DIV_W'(1);
            if (fire) begin
                cmd_cnt <= cmd_cnt + 4'd1;
                // Out-of-range channel fields fall through every branch below.
                if (int'(cmd.ch) < NUM_CH) begin
                    case (cmd.op)
                        OP_SET_DIV: begin
                            div_sh    <= cmd.arg;
                            prescaler <= '0;
                        end
                        OP_SELECT:  out_sel <= cmd.ch;
                        default:    ;
                    endcase
                end
                for (int i = 0; i < NUM_CH; i++)
                    if (cmd.op == OP_SET_MODE && cmd.ch == 2'(i))
                        mode_q[i] <= mode_e'(cmd.arg[1:0]);
            end
        end
    end

    // Channel array; a SET_MODE or CLEAR aimed at a channel suppresses its tick.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic hit;
        logic ch_clr;
        logic ch_tick;

        assign hit     = fire && (cmd.ch == 2'(g));
        assign ch_clr  = hit && (cmd.op == OP_CLEAR);
        assign ch_tick = tick && !(hit && (cmd.op == OP_SET_MODE));

        tt_test_channel #(
            .WIDTH (WIDTH),
            .TAPS  (LFSR_TAPS)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (ch_tick),
            .clear (ch_clr),
            .mode  (mode_q[g]),
            .din   (uio_in),
            .state (state[g])
        );
    end

    // Output views of the selected channel; no added latency.
    always_comb begin
        sel_state = '0;
        sel_mode  = MODE_COUNT;
        for (int i = 0; i < NUM_CH; i++) begin
            if (out_sel == 2'(i)) begin
                sel_state = state[i];
                sel_mode  = mode_q[i];
            end
        end
    end

    assign uo_out  = sel_state;
    assign uio_out = WIDTH'({cmd_cnt, out_sel, sel_mode});
    assign uio_oe  = (sel_mode == MODE_MISR) ? '0 : '1;

endmodule

// File: tb/tb_tt_test_core_mc.sv
// Directed bench for tt_test_core_mc with hand-computed expectations.
module tb_tt_test_core_mc;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    tt_test_core_mc dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One firing edge, then an ena-low edge that drops the strobe without ticking.
    task automatic send(input logic [7:0] c);
        ena   = 1'b1;
        ui_in = c;
        step(1);
        ui_in = 8'h00;
        ena   = 1'b0;
        step(1);
        ena   = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        step(1);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);
        rst = 1'b0;

        // Free count at div_sh=0: one tick per clock.
        step(10);
        chk("count10_uo", uo_out, 8'h0A);
        chk("count10_oe", uio_oe, 8'hFF);
        chk("count10_uio_out", uio_out, 8'h00);

        // SET_DIV 2 with strobe held 5 clocks; the fire edge still ticks.
        ui_in = 8'hA2;
        step(1);
        chk("div_fire_uo", uo_out, 8'h0B);
        step(4);
        ui_in = 8'h00;
        step(8);
        chk("div4_uo", uo_out, 8'h0E);
        chk("held_cmd_cnt", uio_out, 8'h10);

        // ena low: no ticks, commands ignored.
        ena = 1'b0;
        ui_in = 8'hC8;
        step(2);
        ui_in = 8'h00;
        step(4);
        chk("ena_low_uo", uo_out, 8'h0E);
        chk("ena_low_uio_out", uio_out, 8'h10);

        // Back to div 0, park ch0 in HOLD, clear it, then switch to LFSR from zero.
        send(8'hA0);
        send(8'h83);
        send(8'hE0);
        send(8'h81);
        chk("lfsr_start", uo_out, 8'h00);
        step(1);
        chk("lfsr_1", uo_out, 8'h01);
        step(1);
        chk("lfsr_2", uo_out, 8'hB8);
        step(1);
        chk("lfsr_3", uo_out, 8'h5C);
        chk("lfsr_uio_out", uio_out, 8'h51);

        // MISR on ch1 with uio_in=FF.
        uio_in = 8'hFF;
        send(8'h8A);
        send(8'hC8);
        send(8'hE8);
        chk("misr_clr_uo", uo_out, 8'h00);
        chk("misr_oe", uio_oe, 8'h00);
        chk("misr_uio_out", uio_out, 8'h86);
        step(1);
        chk("misr_1", uo_out, 8'hFF);
        step(1);
        // (FF>>1) ^ B8 ^ FF = 7F ^ B8 ^ FF = 38
        chk("misr_2", uo_out, 8'h38);

        // CLEAR ch0 on a tick cycle; ch2 keeps counting.
        send(8'h80);
        send(8'hF0);
        send(8'hC0);
        step(1);
        send(8'hE0);
        chk("clr_on_tick_ch0", uo_out, 8'h00);
        send(8'hD0);
        chk("ch2_still_ticks", uo_out, 8'h04);
        chk("sel_ch2_uio_out", uio_out, 8'hD8);
        chk("sel_ch2_oe", uio_oe, 8'hFF);

        // Mixed config, cmd_cnt wrap, then mid-run reset.
        send(8'hA3);
        send(8'hC8);
        send(8'hC8);
        chk("cmd_cnt_wrap", uio_out, 8'h06);
        chk("pre_rst_oe", uio_oe, 8'h00);
        step(3);
        rst = 1'b1;
        step(1);
        chk("midrst_uo", uo_out, 8'h00);
        chk("midrst_uio_out", uio_out, 8'h00);
        chk("midrst_oe", uio_oe, 8'hFF);
        rst = 1'b0;
        step(1);
        chk("post_rst_tick", uo_out, 8'h01);
        chk("post_rst_uio_out", uio_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
